// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types, constants and helpers for the 3x4 keypad
//               scanner (state encoding, key-code map, column stepping).
// Revision    : 1.0 - initial release
// ============================================================================
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 3;

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;
  localparam logic [3:0] KEY_ZERO = 4'h0;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kp_state_t;

  // Rows 0..2 carry the digits 1..9; the bottom row is '*', '0', '#'.
  function automatic logic [3:0] kp_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = KEY_ZERO;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = KEY_ZERO;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  // Column order 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] kp_next_col(input logic [1:0] col);
    return (col == 2'(NUM_COLS - 1)) ? 2'd0 : col + 2'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_tick.sv
`default_nettype none
// ============================================================================
// Module      : keypad_tick
// Description : Free-running divider; tick is high on the last cycle of
//               every SCAN_DIV-cycle column dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_tick
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 1000
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int                 c_cnt_w = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(SCAN_DIV - 1);

  logic [c_cnt_w-1:0] r_count;

  // Count 0..SCAN_DIV-1 and wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (r_count == c_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign tick = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner
// Description : Scans a 3-column x 4-row active-low keypad, debounces press
//               and release, and emits one key_code/key_valid strobe per
//               press. Optional auto-repeat while held: KEYPAD_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int REPEAT_SCANS = 250
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] key_row,
  output logic [2:0] key_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int                  c_dcnt_w   = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [c_dcnt_w-1:0] c_dcnt_max = c_dcnt_w'(DEBOUNCE_CNT);
  localparam logic                c_single   = (DEBOUNCE_CNT == 1);

  kp_state_t           r_state;
  logic [1:0]          r_col_sel;
  logic [1:0]          r_row_sel;
  logic [c_dcnt_w-1:0] r_pcnt;
  logic [c_dcnt_w-1:0] r_rcnt;

`ifdef KEYPAD_REPEAT_EN
  localparam int                 c_rep_w   = $clog2(REPEAT_SCANS + 1);
  localparam logic [c_rep_w-1:0] c_rep_max = c_rep_w'(REPEAT_SCANS);
  logic [c_rep_w-1:0] r_rep_cnt;
`else
  logic w_unused_repeat;
  assign w_unused_repeat = (REPEAT_SCANS != 0);
`endif

  logic       w_tick;
  logic       w_any_low;
  logic [1:0] w_low_idx;
  logic [3:0] w_sel_mask;
  logic       w_other_low;
  logic       w_same_low;

  keypad_tick #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (w_tick)
  );

  // Row decode: lowest-index low row wins; "same" means only the captured row is low.
  always_comb begin
    w_any_low = ~&key_row;
    w_low_idx = 2'd0;
    for (int i = NUM_ROWS - 1; i >= 0; i--) begin
      if (!key_row[i]) w_low_idx = 2'(i);
    end
    w_sel_mask  = 4'b0001 << r_row_sel;
    w_other_low = |(~key_row & ~w_sel_mask);
    w_same_low  = !key_row[r_row_sel] && !w_other_low;
  end

  assign key_col = 3'b001 << r_col_sel;

  // Scan / debounce / held state machine; all outputs registered.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= SCAN;
      r_col_sel <= 2'd0;
      r_row_sel <= 2'd0;
      r_pcnt    <= '0;
      r_rcnt    <= '0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep_cnt <= '0;
`endif
    end else begin
      key_valid <= 1'b0;
      if (w_tick) begin
        case (r_state)
          SCAN: begin
            if (w_any_low) begin
              r_row_sel <= w_low_idx;
              if (c_single) begin
                key_code  <= kp_code(w_low_idx, r_col_sel);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                r_pcnt    <= '0;
                r_rcnt    <= '0;
                r_state   <= HELD;
              end else begin
                r_pcnt  <= c_dcnt_w'(1);
                r_state <= DEBOUNCE;
              end
            end else begin
              r_col_sel <= kp_next_col(r_col_sel);
            end
          end

          DEBOUNCE: begin
            if (w_same_low) begin
              if (r_pcnt + 1'b1 == c_dcnt_max) begin
                key_code  <= kp_code(r_row_sel, r_col_sel);
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                r_pcnt    <= '0;
                r_rcnt    <= '0;
                r_state   <= HELD;
              end else begin
                r_pcnt <= r_pcnt + 1'b1;
              end
            end else begin
              // Bounce or a different key: drop it and move on.
              r_pcnt    <= '0;
              r_col_sel <= kp_next_col(r_col_sel);
              r_state   <= SCAN;
            end
          end

          HELD: begin
            // Only the captured row matters; other keys are ignored until release.
            if (key_row[r_row_sel]) begin
`ifdef KEYPAD_REPEAT_EN
              r_rep_cnt <= '0;
`endif
              if (r_rcnt + 1'b1 == c_dcnt_max) begin
                key_held  <= 1'b0;
                r_rcnt    <= '0;
                r_col_sel <= kp_next_col(r_col_sel);
                r_state   <= SCAN;
              end else begin
                r_rcnt <= r_rcnt + 1'b1;
              end
            end else begin
              r_rcnt <= '0;
`ifdef KEYPAD_REPEAT_EN
              if (r_rep_cnt + 1'b1 == c_rep_max) begin
                key_valid <= 1'b1;
                r_rep_cnt <= '0;
              end else begin
                r_rep_cnt <= r_rep_cnt + 1'b1;
              end
`endif
            end
          end

          default: r_state <= SCAN;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scanner
// Description : Self-checking bench for keypad_scanner: per-tick stimulus
//               table with expected column/held values, plus a strobe
//               scoreboard holding expected key codes and arrival cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scanner;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_SCANS = 5;

  logic       clk;
  logic       reset_n;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_SCANS (REPEAT_SCANS)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_row   (key_row),
    .key_col   (key_col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // One record per scan dwell: row pattern driven, column and held expected
  // during that dwell, and whether this dwell's tick should cause a strobe.
  typedef struct {
    logic [3:0] row;
    logic [2:0] col;
    logic       held;
    logic       acc;
    logic       rep;
    logic       rst;
    logic [3:0] code;
  } vec_t;

  typedef struct {
    logic [3:0]  code;
    int unsigned at;
  } exp_t;

  vec_t        tbl[$];
  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  logic        prev_valid = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic a(input int n, input logic [3:0] row, input logic [2:0] col, input logic held,
                   input logic acc, input logic rep, input logic rst, input logic [3:0] code);
    for (int j = 0; j < n; j++) tbl.push_back('{row, col, held, acc, rep, rst, code});
  endtask

  // Called #1 after a clock edge; returns #1 after the edge where count is 0.
  task automatic do_reset();
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("rst_col",   {29'd0, key_col}, 32'd1);
    check("rst_code",  {28'd0, key_code}, 32'd0);
    check("rst_valid", {31'd0, key_valid}, 32'd0);
    check("rst_held",  {31'd0, key_held}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // Strobe scoreboard: every strobe must match the oldest expectation in code and cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].at < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL strobe_missing: no key_valid by cycle %0d, required code %0h at cycle %0d", cyc, e.code, e.at);
    end
    if (reset_n === 1'b1 && key_valid !== 1'b0) begin
      check("strobe_gap", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL strobe_unexpected: key_valid=%b code=%0h at cycle %0d, required no strobe", key_valid, key_code, cyc);
      end else begin
        e = exp_q.pop_front();
        check("strobe_code", {28'd0, key_code}, {28'd0, e.code});
        check("strobe_cycle", cyc, e.at);
      end
    end
    prev_valid = (reset_n === 1'b1) && (key_valid === 1'b1);
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench still running at %0t, required completion", $time);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    key_row = 4'hF;

    // Idle scan.
    a(1, 4'hF, 3'b001, 0, 0, 0, 0, 4'h0);
    a(1, 4'hF, 3'b010, 0, 0, 0, 0, 4'h0);
    a(1, 4'hF, 3'b100, 0, 0, 0, 0, 4'h0);
    a(1, 4'hF, 3'b001, 0, 0, 0, 0, 4'h0);
    a(1, 4'hF, 3'b010, 0, 0, 0, 0, 4'h0);
    a(1, 4'hF, 3'b100, 0, 0, 0, 0, 4'h0);
    a(1, 4'hF, 3'b001, 0, 0, 0, 0, 4'h0);
    // '5': row1 at column 010, accepted, then released over 3 ticks.
    a(1, 4'hD, 3'b010, 0, 1, 0, 0, 4'h5);
    a(2, 4'hD, 3'b010, 0, 0, 0, 0, 4'h5);
    a(1, 4'hD, 3'b010, 1, 0, 0, 0, 4'h5);
    a(3, 4'hF, 3'b010, 1, 0, 0, 0, 4'h5);
    a(1, 4'hF, 3'b100, 0, 0, 0, 0, 4'h0);
    // Row3 bounce at column 001: one tick, then released.
    a(1, 4'h7, 3'b001, 0, 0, 0, 0, 4'h0);
    a(1, 4'hF, 3'b001, 0, 0, 0, 0, 4'h0);
    a(1, 4'hF, 3'b010, 0, 0, 0, 0, 4'h0);
    // '#': row3 at column 100, 20 ticks with a one-tick glitch mid-hold.
    a(1, 4'h7, 3'b100, 0, 1, 0, 0, 4'hB);
    a(2, 4'h7, 3'b100, 0, 0, 0, 0, 4'hB);
    a(4, 4'h7, 3'b100, 1, 0, 0, 0, 4'hB);
    a(1, 4'h7, 3'b100, 1, 0, 1, 0, 4'hB);
    a(2, 4'h7, 3'b100, 1, 0, 0, 0, 4'hB);
    a(1, 4'hF, 3'b100, 1, 0, 0, 0, 4'hB);
    a(4, 4'h7, 3'b100, 1, 0, 0, 0, 4'hB);
    a(1, 4'h7, 3'b100, 1, 0, 1, 0, 4'hB);
    a(4, 4'h7, 3'b100, 1, 0, 0, 0, 4'hB);
    a(3, 4'hF, 3'b100, 1, 0, 0, 0, 4'hB);
    a(1, 4'hF, 3'b001, 0, 0, 0, 0, 4'h0);
    // '5' again, interrupted by reset during debounce.
    a(2, 4'hD, 3'b010, 0, 0, 0, 0, 4'h0);
    // After reset: '1' at column 001.
    a(1, 4'hE, 3'b001, 0, 1, 0, 1, 4'h1);
    a(2, 4'hE, 3'b001, 0, 0, 0, 0, 4'h1);
    a(3, 4'hF, 3'b001, 1, 0, 0, 0, 4'h1);
    // '0': row3 at column 010, held 13 ticks past acceptance.
    a(1, 4'h7, 3'b010, 0, 1, 0, 0, 4'h0);
    a(2, 4'h7, 3'b010, 0, 0, 0, 0, 4'h0);
    a(4, 4'h7, 3'b010, 1, 0, 0, 0, 4'h0);
    a(1, 4'h7, 3'b010, 1, 0, 1, 0, 4'h0);
    a(4, 4'h7, 3'b010, 1, 0, 0, 0, 4'h0);
    a(1, 4'h7, 3'b010, 1, 0, 1, 0, 4'h0);
    a(3, 4'h7, 3'b010, 1, 0, 0, 0, 4'h0);
    a(3, 4'hF, 3'b010, 1, 0, 0, 0, 4'h0);
    a(1, 4'hF, 3'b100, 0, 0, 0, 0, 4'h0);

    @(posedge clk);
    #1;
    do_reset();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst) do_reset();
      key_row = tbl[i].row;
      // Acceptance strobe lands (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles after the detecting tick.
      if (tbl[i].acc)
        exp_q.push_back('{tbl[i].code, cyc + SCAN_DIV + (DEBOUNCE_CNT - 1) * SCAN_DIV});
`ifdef KEYPAD_REPEAT_EN
      if (tbl[i].rep)
        exp_q.push_back('{tbl[i].code, cyc + SCAN_DIV});
`endif
      for (int k = 0; k < SCAN_DIV; k++) begin
        @(negedge clk);
        check($sformatf("col_w%0d", i),  {29'd0, key_col},  {29'd0, tbl[i].col});
        check($sformatf("held_w%0d", i), {31'd0, key_held}, {31'd0, tbl[i].held});
      end
      @(posedge clk);
      #1;
    end

    key_row = 4'hF;
    repeat (3 * SCAN_DIV) @(posedge clk);
    @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives the 3-column keypad instead of holding a fixed column, reads the 4 active-low rows, and debounces the reading.
- Outputs one debounced key event per press as a 4-bit key code with a one-cycle valid strobe.
- Sits between the keypad pins and the doorlock FSM, which takes digit entry and reset requests from key_code/key_valid instead of raw row bits.

Parameters:
- SCAN_DIV, 1000: clk cycles each column is driven; rows are sampled on the last cycle of each dwell (the sample tick).
- DEBOUNCE_CNT, 4: consecutive agreeing samples needed to accept a press or a release; must be ≥1.
- REPEAT_SCANS, 250: consecutive held samples between auto-repeat strobes; used only with KEYPAD_REPEAT_EN.

Ports:
- clk, input, 1: system clock.
- reset_n, input, 1: synchronous active-low reset.
- key_row, input, 4: keypad rows; active-low (0 = pressed in the driven column).
- key_col, output, 3: column drive; one-hot, active-high.
- key_code, output, 4: code of the last accepted key.
- key_valid, output, 1: one-cycle strobe; key_code is valid in the same cycle.
- key_held, output, 1: high while the accepted key is still down.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=SCAN, col_sel=0, key_col=3'b001, key_code=0, key_valid=0, key_held=0, all counters 0.
  - Reset mid-press discards the press; no strobe is issued for it.
- Tick:
  - Divider counts 0..SCAN_DIV-1.
  - tick=1 when count==SCAN_DIV-1; key_row is sampled only on tick.
  - key_col = 3'b001 << col_sel.
- SCAN state:
  - On tick with no row low: col_sel advances 0→1→2→0.
  - On tick with any row low: capture row (lowest index wins if several are low), col_sel stays frozen, pcnt=1, go to DEBOUNCE.
- DEBOUNCE state:
  - On tick, if the same row is low: pcnt+1.
  - When pcnt reaches DEBOUNCE_CNT: key_code and key_valid=1 are registered the cycle after that tick; key_held=1; go to HELD.
  - If the row is released, or a different row is low: pcnt=0, advance col_sel, go to SCAN; no strobe.
  - DEBOUNCE_CNT=1: accept on the first detecting tick.
- HELD state:
  - Column stays frozen. key_held stays 1.
  - On tick with the row high: rcnt+1. On tick with the row low: rcnt=0.
  - rcnt==DEBOUNCE_CNT: key_held=0, advance col_sel, go to SCAN.
  - A second key pressed during HELD is ignored until release completes.
- Code map (r=row, c=col):
  - r 0..2: key_code = 3r+c+1 (digits 1..9).
  - r=3: c0 '*'=4'hA, c1 '0'=4'h0, c2 '#'=4'hB.
- Strobe rules:
  - key_valid is never high for two consecutive cycles.
  - key_code holds its value between strobes.
- Latency: key_valid rises exactly (DEBOUNCE_CNT-1)*SCAN_DIV+1 cycles after the detecting tick.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined:
  - In HELD, a repeat counter increments on each tick with the row low and clears on any released tick.
  - When it reaches REPEAT_SCANS: re-strobe key_valid (same key_code) the following cycle and clear the counter.
- Undefined: exactly one strobe per press; the repeat counter logic is absent.

Decomposition:
- Package keypad_pkg:
  - NUM_ROWS=4, NUM_COLS=3.
  - Enum kp_state_t {SCAN, DEBOUNCE, HELD}.
  - Constants KEY_STAR=4'hA, KEY_HASH=4'hB.
  - Function kp_code(row, col) implementing the code map.
- Sub-module keypad_tick: parameterised SCAN_DIV divider producing the one-cycle tick; sync active-low reset to count 0.

Test Plan:
- Bench uses SCAN_DIV=4, DEBOUNCE_CNT=3.
- Idle, key_row=4'hF → key_col cycles 001,010,100 every 4 cycles; key_valid never asserts.
- Hold row1 low while col=010 (key '5') → one key_valid with key_code=4'h5 exactly 9 cycles after the detecting tick; key_held=1 until 3 released ticks; scan resumes at col 100.
- Row3 low at col 001, then released after 1 tick → no strobe; scanning resumes.
- Press '#' (row3, col 100) for 20 ticks, with a 1-tick release glitch mid-hold → single strobe key_code=4'hB; the glitch does not end HELD.
- Assert reset_n=0 during DEBOUNCE → next cycle key_col=001, no strobe; re-press '1' → key_code=4'h1.
- KEYPAD_REPEAT_EN with REPEAT_SCANS=5, hold '0' for 13 ticks past acceptance → 3 strobes, all key_code=4'h0.
